bus_cmd_master: RTL and testbench

BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

---
 rtl/bus_cmd_pkg.sv | 27 ++
 rtl/bus_cmd_master.sv | 195 +++++++++++++++++++
 tb/tb_bus_cmd_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cmd_pkg.sv
// Shared constants and types for the byte-command bus initiator.
// Holds opcodes, response codes and the FSM state encoding.
package bus_cmd_pkg;

    localparam logic [7:0] OP_WRITE_WORD = 8'h57;
    localparam logic [7:0] OP_READ_WORD  = 8'h52;
    localparam logic [7:0] OP_WRITE_BYTE = 8'h42;
    localparam logic [7:0] RSP_ACK       = 8'h06;
    localparam logic [7:0] RSP_NAK       = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE_WORD) || (b == OP_READ_WORD) || (b == OP_WRITE_BYTE);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

endpackage

// File: rtl/bus_cmd_master.sv
// Byte-stream command decoder that issues single bus transactions and
// streams back an ACK, NAK or the little-endian read word.
module bus_cmd_master
    import bus_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    output logic        bus_wen,
    output logic        bus_ren,
    input  logic [31:0] bus_rdata,
    input  logic        bus_done,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    state_e      state_r;
    logic [7:0]  op_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] wait_cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wmask_r;
    logic        wen_r;
    logic        ren_r;
    logic        rx_ready_r;
    logic        tx_valid_r;
    logic [7:0]  tx_data_r;
    logic [23:0] resp_sh_r;
    logic [1:0]  resp_left_r;
    logic        busy_r;
    logic        err_r;

    logic rx_fire_s;
    logic tx_fire_s;
    logic timeout_s;

    assign rx_fire_s = rx_valid && rx_ready_r;
    assign tx_fire_s = tx_valid_r && tx_ready;
    assign timeout_s = (wait_cnt_r == TIMEOUT_M1);

    // Command FSM: field shift-in, bus request, response shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 8'h00;
            byte_cnt_r  <= 2'd0;
            wait_cnt_r  <= 32'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            wmask_r     <= 4'd0;
            wen_r       <= 1'b0;
            ren_r       <= 1'b0;
            rx_ready_r  <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            resp_sh_r   <= 24'd0;
            resp_left_r <= 2'd0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rx_ready_r <= 1'b1;
                    if (rx_fire_s) begin
                        busy_r <= 1'b1;
                        if (is_opcode(rx_data)) begin
                            op_r       <= rx_data;
                            byte_cnt_r <= 2'd0;
                            state_r    <= ST_ADDR;
                        end else begin
                            tx_data_r   <= RSP_NAK;
                            tx_valid_r  <= 1'b1;
                            resp_left_r <= 2'd0;
                            err_r       <= 1'b1;
                            rx_ready_r  <= 1'b0;
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire_s) begin
                        addr_r     <= {rx_data, addr_r[31:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            if (op_r == OP_READ_WORD) begin
                                wmask_r    <= 4'h0;
                                rx_ready_r <= 1'b0;
                                state_r    <= ST_BUS;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire_s) begin
                        if (op_r == OP_WRITE_BYTE) begin
                            // Byte writes put the data on every lane; the mask picks one.
                            wdata_r    <= {4{rx_data}};
                            wmask_r    <= lane_mask(addr_r[1:0]);
                            rx_ready_r <= 1'b0;
                            state_r    <= ST_BUS;
                        end else begin
                            wdata_r    <= {rx_data, wdata_r[31:8]};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (byte_cnt_r == 2'd3) begin
                                wmask_r    <= 4'hF;
                                rx_ready_r <= 1'b0;
                                state_r    <= ST_BUS;
                            end
                        end
                    end
                end
                ST_BUS: begin
                    if (!(wen_r || ren_r)) begin
                        wen_r      <= (op_r != OP_READ_WORD);
                        ren_r      <= (op_r == OP_READ_WORD);
                        wait_cnt_r <= 32'd0;
                    end else if (bus_done) begin
                        // Completion beats a timeout landing in the same cycle.
                        wen_r      <= 1'b0;
                        ren_r      <= 1'b0;
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_RESP;
                        if (ren_r) begin
                            tx_data_r   <= bus_rdata[7:0];
                            resp_sh_r   <= bus_rdata[31:8];
                            resp_left_r <= 2'd3;
                        end else begin
                            tx_data_r   <= RSP_ACK;
                            resp_left_r <= 2'd0;
                        end
                    end else if (timeout_s) begin
                        wen_r       <= 1'b0;
                        ren_r       <= 1'b0;
                        tx_valid_r  <= 1'b1;
                        tx_data_r   <= RSP_NAK;
                        resp_left_r <= 2'd0;
                        err_r       <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (tx_fire_s) begin
                        if (resp_left_r == 2'd0) begin
                            tx_valid_r <= 1'b0;
                            busy_r     <= 1'b0;
                            rx_ready_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            tx_data_r   <= resp_sh_r[7:0];
                            resp_sh_r   <= {8'h00, resp_sh_r[23:8]};
                            resp_left_r <= resp_left_r - 2'd1;
                        end
                    end
                end
                default: begin
                    wen_r      <= 1'b0;
                    ren_r      <= 1'b0;
                    tx_valid_r <= 1'b0;
                    rx_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready  = rx_ready_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign bus_addr  = addr_r;
    assign bus_wdata = wdata_r;
    assign bus_wmask = wmask_r;
    assign bus_wen   = wen_r;
    assign bus_ren   = ren_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed self-checking bench for bus_cmd_master with hand-computed
// expectations for write, read, byte-write, NAK, timeout and reset.
module tb_bus_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_done;
    logic        busy;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_cmd_master #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done),
        .busy      (busy),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("rx_ready", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int stall);
        int n;
        logic [7:0] held;
        n = 0;
        tx_ready = 1'b0;
        while (!tx_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("tx_valid", 32'(tx_valid), 32'd1);
        held = tx_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held}));
        end
        check_eq("tx_data", 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!(bus_wen || bus_ren) && n < 50) begin
            tick();
            n++;
        end
        check_eq("req_seen", 32'(bus_wen || bus_ren), 32'd1);
    endtask

    task automatic bus_phase(input logic is_write, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                             input int delay, input logic [31:0] rdata);
        wait_req();
        check_eq("bus_wen", 32'(bus_wen), 32'(is_write));
        check_eq("bus_ren", 32'(bus_ren), 32'(!is_write));
        check_eq("bus_addr", bus_addr, exp_addr);
        check_eq("bus_wmask", 32'(bus_wmask), 32'(exp_mask));
        if (is_write) check_eq("bus_wdata", bus_wdata, exp_wdata);
        check_eq("rx_ready_bus", 32'(rx_ready), 32'd0);
        check_eq("busy_bus", 32'(busy), 32'd1);
        for (int i = 1; i < delay; i++) begin
            tick();
            check_eq("addr_hold", bus_addr, exp_addr);
            check_eq("req_hold", 32'({bus_wen, bus_ren}), 32'({is_write, !is_write}));
        end
        bus_rdata = rdata;
        bus_done  = 1'b1;
        tick();
        bus_done  = 1'b0;
        bus_rdata = 32'd0;
        check_eq("req_drop", 32'({bus_wen, bus_ren}), 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        bus_rdata = 32'd0;
        bus_done  = 1'b0;
        tick();
        tick();
        check_eq("rst_outs", 32'({rx_ready, tx_valid, busy, err, bus_wen, bus_ren, bus_wmask}), 32'd0);
        check_eq("rst_addr", bus_addr, 32'd0);
        check_eq("rst_wdata", bus_wdata, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rx_ready_post_rst", 32'(rx_ready), 32'd1);

        // Write word
        send_byte(8'h57);
        send_word(32'h0000_0100);
        send_word(32'hDEAD_BEEF);
        bus_phase(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 32'd0);
        recv_byte(8'h06, 0);
        check_eq("idle_after_w", 32'({busy, tx_valid, rx_ready}), 32'b001);

        // Read word with a mid-stream stall
        send_byte(8'h52);
        send_word(32'h0000_0104);
        bus_phase(1'b0, 32'h0000_0104, 32'd0, 4'h0, 2, 32'h1234_5678);
        recv_byte(8'h78, 0);
        recv_byte(8'h56, 5);
        recv_byte(8'h34, 0);
        recv_byte(8'h12, 0);
        check_eq("idle_after_r", 32'({busy, tx_valid}), 32'd0);

        // Write byte
        send_byte(8'h42);
        send_word(32'h0000_0203);
        send_byte(8'hA5);
        bus_phase(1'b1, 32'h0000_0203, 32'hA5A5_A5A5, 4'b1000, 1, 32'd0);
        recv_byte(8'h06, 0);

        // Unknown opcode then a good read
        check_eq("err_before_nak", 32'(err), 32'd0);
        send_byte(8'h00);
        recv_byte(8'h15, 0);
        check_eq("err_after_nak", 32'(err), 32'd1);
        send_byte(8'h52);
        send_word(32'h0000_0040);
        bus_phase(1'b0, 32'h0000_0040, 32'd0, 4'h0, 4, 32'hCAFE_F00D);
        recv_byte(8'h0D, 0);
        recv_byte(8'hF0, 0);
        recv_byte(8'hFE, 0);
        recv_byte(8'hCA, 0);

        // Reset while the read request is pending
        send_byte(8'h52);
        send_word(32'h0000_000C);
        wait_req();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'({bus_ren, bus_wen, busy, tx_valid, rx_ready, err}), 32'd0);
        check_eq("rst_mid_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rx_ready_rerst", 32'(rx_ready), 32'd1);
        send_byte(8'h57);
        send_word(32'h0000_0010);
        send_word(32'h1122_3344);
        bus_phase(1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 2, 32'd0);
        recv_byte(8'h06, 0);

        // Timeout with no completion
        check_eq("err_pre_timeout", 32'(err), 32'd0);
        send_byte(8'h52);
        send_word(32'h0000_0080);
        wait_req();
        n = 0;
        while (bus_ren && n < 50) begin
            tick();
            n++;
        end
        check_eq("timeout_len", 32'(n), 32'd16);
        recv_byte(8'h15, 0);
        check_eq("err_timeout", 32'(err), 32'd1);

        // Completion on the final allowed cycle wins over the timeout
        send_byte(8'h52);
        send_word(32'h0000_0084);
        wait_req();
        for (int i = 0; i < 15; i++) tick();
        check_eq("ren_at_16", 32'(bus_ren), 32'd1);
        bus_rdata = 32'h0BAD_C0DE;
        bus_done  = 1'b1;
        tick();
        bus_done  = 1'b0;
        bus_rdata = 32'd0;
        check_eq("ren_drop_16", 32'(bus_ren), 32'd0);
        recv_byte(8'hDE, 0);
        recv_byte(8'hC0, 0);
        recv_byte(8'hAD, 0);
        recv_byte(8'h0B, 0);
        check_eq("idle_final", 32'({busy, tx_valid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
